// File: rtl/apb_rr_pkg.sv
// Shared types and helpers for the round-robin APB3 master.
package apb_rr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Increment an index modulo n (n need not be a power of two).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/apb_rr_if.sv
// Bundle of requester-side and APB-side signals of the round-robin master.
//
// Handshake semantics:
//   A requester raises req_valid[i] with req_write/req_addr/req_wdata stable and
//   keeps them until req_ready[i] pulses (one cycle, one-hot) -- that pulse is the
//   capture point. Dropping req_valid[i] before req_ready[i] withdraws the request.
//   rsp_valid[i] pulses for one cycle when the transfer ends; rsp_rdata and
//   rsp_err are meaningful only in that cycle. There is no backpressure on rsp.
interface apb_rr_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // requester side
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_write;
  logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]            rsp_rdata;
  logic                         rsp_err;

  // APB side
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport requester (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin grant: first set request at or after ptr_i, wrapping.
module apb_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from the pointer upward and take the first active requester.
  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB3 master sharing one bus among N_REQ requesters with round-robin grant.
// IDLE -> SETUP -> ACCESS -> IDLE; every output is registered.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that waits
// TIMEOUT_CYCLES cycles on PREADY (response then carries rsp_err=1, rsp_rdata=0).
module apb_rr_master
  import apb_rr_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  apb_rr_if.master   bus,
  output apb_state_e state_o
);

  localparam int PTR_W = ptr_width(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_rr_master: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  apb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  gidx_q, gidx_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [N_REQ-1:0]  req_ready_q, req_ready_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic [N_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0] arb_idx;
  logic             arb_any;

  apb_rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Next-state and output-register values; everything holds unless a phase changes it.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // Requests are only sampled here, so an in-flight requester is never re-granted early.
        if (arb_any) begin
          req_ready_d = arb_gnt;
          gidx_d      = arb_idx;
          ptr_d       = PTR_W'(wrap_inc(int'(arb_idx), N_REQ));
          pwrite_d    = bus.req_write[arb_idx];
          paddr_d     = bus.req_addr[arb_idx];
          pwdata_d    = bus.req_wdata[arb_idx];
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (bus.PREADY) begin
          rsp_valid_d[gidx_q] = 1'b1;
          if (!pwrite_q) rsp_rdata_d = bus.PRDATA;
          rsp_err_d = bus.PSLVERR;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_d[gidx_q] = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any transfer in progress.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: 16-byte register slave with registered PREADY,
// directed requester traffic, grant/response scoreboards.
module tb_apb_rr_master;
  import apb_rr_pkg::*;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int W      = N_REQ + DATA_W + 1;
`ifdef APB_TIMEOUT_EN
  localparam int T5_ACCESS_CYCLES = 16;
`else
  localparam int T5_ACCESS_CYCLES = 22;
`endif

  // ---------------- clock / reset ----------------
  logic PCLK = 1'b0;
  logic PRESETn;
  always #5 PCLK = ~PCLK;

  apb_rr_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  apb_state_e state;

  apb_rr_master #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- slave model ----------------
  int          wait_cfg;
  int          s_cnt;
  logic        s_ready, s_err;
  logic [31:0] s_rdata;
  logic [31:0] mem [4];

  assign bus.PREADY  = s_ready;
  assign bus.PRDATA  = s_rdata;
  assign bus.PSLVERR = s_err;

  always @(posedge PCLK) begin
    if (!PRESETn || !bus.PSEL) begin
      s_ready <= 1'b0;
      s_err   <= 1'b0;
      s_cnt   <= 0;
    end else if (bus.PENABLE && !s_ready) begin
      if (s_cnt >= wait_cfg) begin
        s_ready <= 1'b1;
        if (bus.PADDR[1:0] != 2'b00 || bus.PADDR >= 32'd16) begin
          s_err   <= 1'b1;
          s_rdata <= 32'hBAD0BAD0;
        end else begin
          s_err <= 1'b0;
          if (bus.PWRITE) mem[bus.PADDR[3:2]] <= bus.PWDATA;
          else            s_rdata <= mem[bus.PADDR[3:2]];
        end
      end else begin
        s_cnt <= s_cnt + 1;
      end
    end else if (s_ready) begin
      s_ready <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0]     exp_q[$];
  logic [N_REQ-1:0] gnt_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rsp(input int idx, input logic [31:0] d, input logic e);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return {oh, d, e};
  endfunction

  function automatic logic [N_REQ-1:0] oh(input int idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Pops expected grants/responses as the DUT presents them; also watches APB phase rules.
  task automatic monitor();
    apb_state_e        prev_state = IDLE;
    logic              prev_psel  = 1'b0;
    logic [ADDR_W-1:0] setup_addr = '0;
    logic [W-1:0]      e;
    logic [N_REQ-1:0]  g;
    forever begin
      @(negedge PCLK);
      if (|bus.req_ready) begin
        if (gnt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant act=%b exp=none", bus.req_ready);
        end else begin
          g = gnt_q.pop_front();
          chk("grant", 64'(bus.req_ready), 64'(g));
        end
      end
      if (|bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp act=%h exp=none", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err});
        end else begin
          e = exp_q.pop_front();
          chk("rsp", 64'({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}), 64'(e));
        end
      end
      if (PRESETn) begin
        if (bus.PSEL && !bus.PENABLE) begin
          chk("setup_gap_prev_psel", 64'(prev_psel), 64'(0));
          setup_addr = bus.PADDR;
        end
        if (bus.PSEL && bus.PENABLE)
          chk("access_paddr_stable", 64'(bus.PADDR), 64'(setup_addr));
        if (prev_state == SETUP)
          chk("setup_one_cycle", 64'(state), 64'(ACCESS));
      end
      prev_state = state;
      prev_psel  = bus.PSEL;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_psel",      64'(bus.PSEL), 0);
    chk("rst_penable",   64'(bus.PENABLE), 0);
    chk("rst_pwrite",    64'(bus.PWRITE), 0);
    chk("rst_paddr",     64'(bus.PADDR), 0);
    chk("rst_pwdata",    64'(bus.PWDATA), 0);
    chk("rst_req_ready", 64'(bus.req_ready), 0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 0);
    chk("rst_rsp_err",   64'(bus.rsp_err), 0);
    chk("rst_state",     64'(state), 64'(IDLE));
    PRESETn = 1'b1;
  endtask

  // Single request; called at a negedge, returns at the negedge showing req_ready.
  task automatic issue(input int idx, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    bit got = 1'b0;
    bus.req_valid[idx] = 1'b1;
    bus.req_write[idx] = wr;
    bus.req_addr[idx]  = a;
    bus.req_wdata[idx] = d;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge PCLK);
      if (bus.req_ready[idx]) got = 1'b1;
    end
    bus.req_valid[idx] = 1'b0;
    chk("grant_wait", 64'(got), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || gnt_q.size() != 0); i++)
      @(negedge PCLK);
    chk("drain_rsp", 64'(exp_q.size()), 0);
    chk("drain_gnt", 64'(gnt_q.size()), 0);
  endtask

  // ---------------- directed tests ----------------
  logic [31:0] dv [3];
  int c0, c1, n;
  bit done;

  initial begin
    PRESETn       = 1'b0;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    wait_cfg      = 0;
    dv[0] = 32'h11110000; dv[1] = 32'h22221111; dv[2] = 32'h33332222;
    fork
      monitor();
    join_none

    apply_reset();

    // T1: write then read back through the other requester
    wait_cfg = 1;
    gnt_q.push_back(oh(0)); exp_q.push_back(rsp(0, 32'h0, 1'b0));
    issue(0, 1'b1, 32'h4, 32'hDEADBEEF);
    drain();
    gnt_q.push_back(oh(1)); exp_q.push_back(rsp(1, 32'hDEADBEEF, 1'b0));
    issue(1, 1'b0, 32'h4, 32'h0);
    drain();

    // T2: both held valid after reset -> alternating grants
    apply_reset();
    wait_cfg = 0;
    for (int k = 0; k < 3; k++) begin
      gnt_q.push_back(oh(0));
      gnt_q.push_back(oh(1));
    end
    exp_q.push_back(rsp(0, 32'h0,  1'b0));
    exp_q.push_back(rsp(1, dv[0], 1'b0));
    exp_q.push_back(rsp(0, dv[0], 1'b0));
    exp_q.push_back(rsp(1, dv[1], 1'b0));
    exp_q.push_back(rsp(0, dv[1], 1'b0));
    exp_q.push_back(rsp(1, dv[2], 1'b0));
    bus.req_valid = 2'b11;
    bus.req_write = 2'b01;
    bus.req_addr[0] = 32'h8; bus.req_addr[1] = 32'h8;
    bus.req_wdata[0] = dv[0];
    c0 = 0; c1 = 0;
    for (int i = 0; i < 200 && (c0 + c1) < 6; i++) begin
      @(negedge PCLK);
      if (bus.req_ready[0]) begin
        c0++;
        if (c0 == 3) bus.req_valid[0] = 1'b0;
        else         bus.req_wdata[0] = dv[c0];
      end
      if (bus.req_ready[1]) begin
        c1++;
        if (c1 == 3) bus.req_valid[1] = 1'b0;
      end
    end
    bus.req_valid = '0;
    chk("t2_grant_count", 64'(c0 + c1), 6);
    drain();

    // T3: slave error, then clean transfer
    gnt_q.push_back(oh(1)); exp_q.push_back(rsp(1, dv[2], 1'b1));
    issue(1, 1'b1, 32'h5, 32'h0000CAFE);
    gnt_q.push_back(oh(0)); exp_q.push_back(rsp(0, dv[2], 1'b0));
    issue(0, 1'b0, 32'h8, 32'h0);
    drain();

    // T4: reset during ACCESS discards the transfer; pointer restarts at 0
    wait_cfg = 5;
    gnt_q.push_back(oh(0));
    issue(0, 1'b1, 32'hC, 32'h00001234);
    for (int i = 0; i < 20 && state != ACCESS; i++) @(negedge PCLK);
    chk("t4_in_access", 64'(state), 64'(ACCESS));
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    chk("t4_psel_drop",    64'(bus.PSEL), 0);
    chk("t4_penable_drop", 64'(bus.PENABLE), 0);
    chk("t4_no_rsp",       64'(bus.rsp_valid), 0);
    apply_reset();
    wait_cfg = 0;
    gnt_q.push_back(oh(0)); exp_q.push_back(rsp(0, 32'hDEADBEEF, 1'b0));
    gnt_q.push_back(oh(1)); exp_q.push_back(rsp(1, dv[2], 1'b0));
    bus.req_write = 2'b00;
    bus.req_addr[1] = 32'h8;
    bus.req_addr[0] = 32'h4;
    bus.req_valid = 2'b11;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 60 && (c0 + c1) < 2; i++) begin
      @(negedge PCLK);
      if (bus.req_ready[0]) begin c0++; bus.req_valid[0] = 1'b0; end
      if (bus.req_ready[1]) begin c1++; bus.req_valid[1] = 1'b0; end
    end
    bus.req_valid = '0;
    chk("t4_grant_count", 64'(c0 + c1), 2);
    drain();

    // T5: slave stalls PREADY for 20 cycles
    wait_cfg = 20;
    gnt_q.push_back(oh(0));
`ifdef APB_TIMEOUT_EN
    exp_q.push_back(rsp(0, 32'h0, 1'b1));
`else
    exp_q.push_back(rsp(0, 32'hDEADBEEF, 1'b0));
`endif
    issue(0, 1'b0, 32'h4, 32'h0);
    n = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge PCLK);
      if (state == ACCESS) n++;
      if (|bus.rsp_valid) done = 1'b1;
    end
    chk("t5_completed", 64'(done), 1);
    chk("t5_access_cycles", 64'(n), 64'(T5_ACCESS_CYCLES));
    drain();

    // T6: req0 address wiggles while req1 owns the bus; only the value at grant counts
    wait_cfg = 2;
    gnt_q.push_back(oh(1)); exp_q.push_back(rsp(1, 32'hDEADBEEF, 1'b0));
    gnt_q.push_back(oh(0)); exp_q.push_back(rsp(0, 32'hDEADBEEF, 1'b0));
    bus.req_valid[1] = 1'b1; bus.req_write[1] = 1'b0; bus.req_addr[1] = 32'h4;
    done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge PCLK);
      if (bus.req_valid[0] && bus.req_ready[0]) begin
        chk("t6_paddr_at_grant", 64'(bus.PADDR), 64'h0000000C);
        bus.req_valid[0] = 1'b0;
        done = 1'b1;
      end else begin
        if (bus.req_ready[1]) begin
          bus.req_valid[1] = 1'b0;
          bus.req_valid[0] = 1'b1;
          bus.req_write[0] = 1'b1;
          bus.req_wdata[0] = 32'h00000055;
        end
        if (bus.req_valid[0])
          bus.req_addr[0] = bus.PSEL ? (32'h100 + 32'(k)) : 32'hC;
      end
    end
    chk("t6_req0_granted", 64'(done), 1);
    gnt_q.push_back(oh(1)); exp_q.push_back(rsp(1, 32'h00000055, 1'b0));
    issue(1, 1'b0, 32'hC, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
